// File: rtl/memory_stage_pkg.sv
// ---------------------------------------------------------------------------
// memory_stage_pkg
// Shared types for the MEM stage: word/register index types, the write-back
// source select encoding and the data-memory handshake FSM states.
// ---------------------------------------------------------------------------
package memory_stage_pkg;
   localparam int WORD_W = 32;
   localparam int REG_W  = 5;

   typedef logic [WORD_W-1:0] word_t;
   typedef logic [REG_W-1:0]  regbits_t;

   // Write-back source; code 2'd3 is unused and falls back to the ALU result.
   typedef enum logic [1:0] {
      SEL_ALU = 2'd0,
      SEL_MEM = 2'd1,
      SEL_PC  = 2'd2
   } regsel_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } mem_state_t;
endpackage

// File: rtl/mem_wb_latch.sv
// ---------------------------------------------------------------------------
// mem_wb_latch
// MEM/WB pipeline register. Loads on an enabled clock edge; flush on that
// same edge loads a bubble (all zero) instead of the incoming values.
// Ports:
//   CLK, nRST            clock, asynchronous active-low reset
//   en                   advance strobe (ihit & ~mem_stall)
//   flush                load a bubble on the next enabled edge
//   regWr_in/regDst_in   write enable / destination from MEM
//   wdat_in              selected write-back data from MEM
//   regWr_wb/regDst_wb/wdat_wb   registered outputs toward WB
// ---------------------------------------------------------------------------
module mem_wb_latch #(
   parameter int DW = 32,
   parameter int RW = 5
) (
   input  logic          CLK,
   input  logic          nRST,
   input  logic          en,
   input  logic          flush,
   input  logic          regWr_in,
   input  logic [RW-1:0] regDst_in,
   input  logic [DW-1:0] wdat_in,
   output logic          regWr_wb,
   output logic [RW-1:0] regDst_wb,
   output logic [DW-1:0] wdat_wb
);

   always_ff @(posedge CLK, negedge nRST) begin
      if (!nRST) begin
         regWr_wb  <= 1'b0;
         regDst_wb <= '0;
         wdat_wb   <= '0;
      end else if (en) begin
         if (flush) begin
            regWr_wb  <= 1'b0;
            regDst_wb <= '0;
            wdat_wb   <= '0;
         end else begin
            regWr_wb  <= regWr_in;
            regDst_wb <= regDst_in;
            wdat_wb   <= wdat_in;
         end
      end
   end

endmodule

// File: rtl/memory_stage.sv
// ---------------------------------------------------------------------------
// memory_stage
// MEM stage of the 5-stage pipeline. Issues one dcache request per EX/MEM
// instruction, stalls until dhit, picks the write-back value and feeds the
// MEM/WB latch.
// Ports:
//   CLK, nRST                  clock, asynchronous active-low reset
//   ihit, flush                pipeline advance strobe, MEM/WB bubble request
//   nPC_in, ALUOut_in, rdat2_in, dREN_in, dWEN_in, regWr_in, regSel_in,
//   regDst_in                  EX/MEM latch contents
//   dmemREN, dmemWEN, dmemaddr, dmemstore   dcache request
//   dhit, dmemload             dcache completion pulse and read data
//   mem_stall                  stall toward the hazard unit
//   regWr_wb, regDst_wb, wdat_wb            MEM/WB latch outputs
// ---------------------------------------------------------------------------
module memory_stage
   import memory_stage_pkg::*;
#(
   parameter int DW = 32,
   parameter int RW = 5
) (
   input  logic          CLK,
   input  logic          nRST,
   input  logic          ihit,
   input  logic          flush,
   input  logic [DW-1:0] nPC_in,
   input  logic [DW-1:0] ALUOut_in,
   input  logic [DW-1:0] rdat2_in,
   input  logic          dREN_in,
   input  logic          dWEN_in,
   input  logic          regWr_in,
   input  logic [1:0]    regSel_in,
   input  logic [RW-1:0] regDst_in,
   output logic          dmemREN,
   output logic          dmemWEN,
   output logic [DW-1:0] dmemaddr,
   output logic [DW-1:0] dmemstore,
   input  logic          dhit,
   input  logic [DW-1:0] dmemload,
   output logic          mem_stall,
   output logic          regWr_wb,
   output logic [RW-1:0] regDst_wb,
   output logic [DW-1:0] wdat_wb
);

   mem_state_t    state, next_state;
   logic          access, req, capture;
   logic [DW-1:0] ldbuf, lddata, wdat;

   assign access = dREN_in | dWEN_in;
   // DONE means this instruction's transaction already completed; it must
   // not be reissued while the pipeline waits for ihit.
   assign req     = access & (state != DONE);
   assign capture = req & dhit;

   // Load wins when both enables are set.
   assign dmemREN   = req & dREN_in;
   assign dmemWEN   = req & dWEN_in & ~dREN_in;
   assign dmemaddr  = {ALUOut_in[DW-1:2], 2'b00};
   assign dmemstore = rdat2_in;
   assign mem_stall = req & ~dhit;

   always_ff @(posedge CLK, negedge nRST) begin
      if (!nRST) begin
         state <= IDLE;
         ldbuf <= '0;
      end else begin
         state <= next_state;
         if (capture)
            ldbuf <= dmemload;
      end
   end

   // A completion that coincides with ihit retires immediately, so the FSM
   // skips DONE and the latch takes dmemload directly.
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (access) next_state = dhit ? (ihit ? IDLE : DONE) : WAIT;
         WAIT:    if (dhit)   next_state = ihit ? IDLE : DONE;
         DONE:    if (ihit)   next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   assign lddata = capture ? dmemload : ldbuf;

   always_comb begin
      wdat = ALUOut_in;
      case (regSel_in)
         SEL_MEM: wdat = lddata;
         SEL_PC:  wdat = nPC_in;
         default: wdat = ALUOut_in;
      endcase
   end

   mem_wb_latch #(.DW(DW), .RW(RW)) u_mem_wb (
      .CLK       (CLK),
      .nRST      (nRST),
      .en        (ihit & ~mem_stall),
      .flush     (flush),
      .regWr_in  (regWr_in),
      .regDst_in (regDst_in),
      .wdat_in   (wdat),
      .regWr_wb  (regWr_wb),
      .regDst_wb (regDst_wb),
      .wdat_wb   (wdat_wb)
   );

endmodule

// File: tb/tb_memory_stage.sv
module tb_memory_stage;
   import memory_stage_pkg::*;

   localparam int DW = 32;
   localparam int RW = 5;

   logic          CLK = 1'b0;
   logic          nRST;
   logic          ihit, flush, dREN_in, dWEN_in, regWr_in, dhit;
   logic [DW-1:0] nPC_in, ALUOut_in, rdat2_in, dmemload;
   logic [1:0]    regSel_in;
   logic [RW-1:0] regDst_in;
   logic          dmemREN, dmemWEN, mem_stall, regWr_wb;
   logic [DW-1:0] dmemaddr, dmemstore, wdat_wb;
   logic [RW-1:0] regDst_wb;

   memory_stage #(.DW(DW), .RW(RW)) dut (
      .CLK(CLK), .nRST(nRST), .ihit(ihit), .flush(flush),
      .nPC_in(nPC_in), .ALUOut_in(ALUOut_in), .rdat2_in(rdat2_in),
      .dREN_in(dREN_in), .dWEN_in(dWEN_in), .regWr_in(regWr_in),
      .regSel_in(regSel_in), .regDst_in(regDst_in),
      .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr),
      .dmemstore(dmemstore), .dhit(dhit), .dmemload(dmemload),
      .mem_stall(mem_stall), .regWr_wb(regWr_wb), .regDst_wb(regDst_wb),
      .wdat_wb(wdat_wb)
   );

   always #5 CLK = ~CLK;

   int checks = 0;
   int errors = 0;

   // Instruction-level reference: has the current instruction's memory
   // transaction completed, what was last loaded, and what WB should hold.
   logic        m_done;
   logic [31:0] m_ld;
   logic        m_regwr;
   logic [4:0]  m_dst;
   logic [31:0] m_wdat;
   logic        retired;
   int          stall_seen, req_seen;

   typedef struct {
      logic [1:0]  sel;
      logic [31:0] alu, npc, rd2, ld;
      logic        ren, wen, rw;
      logic [4:0]  dst;
      int          delay;
      logic        fl;
      logic [31:0] e_addr, e_wdat;
      logic        e_rw;
      logic [4:0]  e_dst;
      int          e_stalls, e_reqs;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] wb_value(input logic [1:0] sel, input logic [31:0] alu,
                                            input logic [31:0] npc, input logic [31:0] ld);
      case (sel)
         2'd1:    return ld;
         2'd2:    return npc;
         default: return alu;
      endcase
   endfunction

   task automatic model_reset();
      m_done = 1'b0; m_ld = '0; m_regwr = 1'b0; m_dst = '0; m_wdat = '0;
   endtask

   task automatic set_instr(input logic [1:0] sel, input logic [31:0] alu, input logic [31:0] npc,
                            input logic [31:0] rd2, input logic ren, input logic wen,
                            input logic rw, input logic [4:0] dst);
      regSel_in = sel; ALUOut_in = alu; nPC_in = npc; rdat2_in = rd2;
      dREN_in = ren; dWEN_in = wen; regWr_in = rw; regDst_in = dst;
   endtask

   // One clock: called just after a rising edge; checks at the falling edge,
   // advances the model, returns just after the next rising edge.
   task automatic step(input logic ih, input logic dh, input logic fl);
      logic req, stall, cap;
      logic [31:0] ld;
      ihit = ih; dhit = dh; flush = fl;
      @(negedge CLK);
      req   = (dREN_in | dWEN_in) & ~m_done;
      stall = req & ~dh;
      chk("dmemREN", dmemREN, req & dREN_in);
      chk("dmemWEN", dmemWEN, req & dWEN_in & ~dREN_in);
      if (req) begin
         chk("dmemaddr", dmemaddr, ALUOut_in & 32'hFFFF_FFFC);
         chk("dmemstore", dmemstore, rdat2_in);
      end
      chk("mem_stall", mem_stall, stall);
      chk("regWr_wb", regWr_wb, m_regwr);
      chk("regDst_wb", regDst_wb, m_dst);
      chk("wdat_wb", wdat_wb, m_wdat);
      if (mem_stall) stall_seen++;
      if (dmemREN | dmemWEN) req_seen++;
      cap = req & dh;
      ld  = cap ? dmemload : m_ld;
      retired = ih & ~stall;
      if (retired) begin
         if (fl) begin
            m_regwr = 1'b0; m_dst = '0; m_wdat = '0;
         end else begin
            m_regwr = regWr_in; m_dst = regDst_in;
            m_wdat  = wb_value(regSel_in, ALUOut_in, nPC_in, ld);
         end
         m_done = 1'b0;
      end else if (cap) begin
         m_done = 1'b1;
      end
      if (cap) m_ld = dmemload;
      @(posedge CLK);
      #1;
   endtask

   // Run the presented instruction until it leaves MEM; dcache answers
   // 'delay' request cycles after the request first appears.
   task automatic run_instr(input int delay, input logic fl, input bit rand_ihit,
                            input logic [31:0] ld_val);
      int   waited;
      logic ih, dh, req;
      waited = 0;
      stall_seen = 0; req_seen = 0;
      for (int c = 0; c < 40; c++) begin
         req = (dREN_in | dWEN_in) & ~m_done;
         dh  = req && (waited >= delay);
         if (req) waited++;
         ih  = rand_ihit ? ($urandom_range(0, 3) != 0) : 1'b1;
         dmemload = dh ? ld_val : $urandom;
         step(ih, dh, fl);
         if (retired) return;
      end
      chk("retire_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{SEL_MEM, 32'h104, 32'h10, 32'h0, 32'hDEADBEEF, 1, 0, 1, 5'd8, 3, 0,
                  32'h104, 32'hDEADBEEF, 1, 5'd8, 3, 4};
      vecs[1] = '{SEL_ALU, 32'h203, 32'h14, 32'h12345678, 32'h0, 0, 1, 0, 5'd0, 0, 0,
                  32'h200, 32'h203, 0, 5'd0, 0, 1};
      vecs[2] = '{SEL_ALU, 32'h42, 32'h18, 32'h0, 32'h0, 0, 0, 1, 5'd3, 0, 0,
                  32'h40, 32'h42, 1, 5'd3, 0, 0};
      vecs[3] = '{SEL_PC, 32'h99, 32'h20, 32'h0, 32'h0, 0, 0, 1, 5'd31, 0, 0,
                  32'h98, 32'h20, 1, 5'd31, 0, 0};
      vecs[4] = '{SEL_MEM, 32'h300, 32'h24, 32'h0, 32'hA5A5A5A5, 1, 0, 1, 5'd9, 2, 1,
                  32'h300, 32'h0, 0, 5'd0, 2, 3};
      vecs[5] = '{2'd3, 32'h77, 32'h28, 32'h0, 32'h0, 0, 0, 1, 5'd4, 0, 0,
                  32'h74, 32'h77, 1, 5'd4, 0, 0};
      vecs[6] = '{SEL_MEM, 32'h1FE, 32'h2C, 32'h11, 32'hCAFE0001, 1, 1, 1, 5'd7, 1, 0,
                  32'h1FC, 32'hCAFE0001, 1, 5'd7, 1, 2};
      vecs[7] = '{SEL_MEM, 32'h40C, 32'h30, 32'h0, 32'h0BADF00D, 1, 0, 1, 5'd12, 0, 0,
                  32'h40C, 32'h0BADF00D, 1, 5'd12, 0, 1};

      // Reset state
      nRST = 1'b0; ihit = 0; flush = 0; dhit = 0; dmemload = '0;
      set_instr(SEL_ALU, 32'h0, 32'h0, 32'h0, 0, 0, 0, 5'd0);
      model_reset();
      repeat (2) @(posedge CLK);
      #1;
      chk("reset_regWr_wb", regWr_wb, 0);
      chk("reset_regDst_wb", regDst_wb, 0);
      chk("reset_wdat_wb", wdat_wb, 0);
      chk("reset_mem_stall", mem_stall, 0);
      nRST = 1'b1;

      // Table vectors, ihit held high
      for (int i = 0; i < 8; i++) begin
         set_instr(vecs[i].sel, vecs[i].alu, vecs[i].npc, vecs[i].rd2,
                   vecs[i].ren, vecs[i].wen, vecs[i].rw, vecs[i].dst);
         #1;
         if (vecs[i].ren | vecs[i].wen)
            chk($sformatf("vec%0d_addr", i), dmemaddr, vecs[i].e_addr);
         run_instr(vecs[i].delay, vecs[i].fl, 1'b0, vecs[i].ld);
         chk($sformatf("vec%0d_stalls", i), stall_seen, vecs[i].e_stalls);
         chk($sformatf("vec%0d_reqs", i), req_seen, vecs[i].e_reqs);
         chk($sformatf("vec%0d_regWr_wb", i), regWr_wb, vecs[i].e_rw);
         chk($sformatf("vec%0d_regDst_wb", i), regDst_wb, vecs[i].e_dst);
         chk($sformatf("vec%0d_wdat_wb", i), wdat_wb, vecs[i].e_wdat);
      end

      // Store completes with ihit low: waits in DONE without reissuing
      set_instr(SEL_ALU, 32'h203, 32'h40, 32'h12345678, 0, 1, 0, 5'd0);
      dmemload = 32'h0;
      step(1'b0, 1'b1, 1'b0);
      chk("store_done_wen", dmemWEN, 0);
      chk("store_done_stall", mem_stall, 0);
      step(1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      chk("store_ret_regWr", regWr_wb, 0);
      chk("store_ret_wdat", wdat_wb, 32'h203);

      // Load completes with ihit low: write-back uses the buffered load data
      set_instr(SEL_MEM, 32'h500, 32'h44, 32'h0, 1, 0, 1, 5'd6);
      dmemload = 32'h11111111;
      step(1'b0, 1'b0, 1'b0);
      dmemload = 32'h13579BDF;
      step(1'b0, 1'b1, 1'b0);
      dmemload = 32'hFFFF0000;
      step(1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      chk("ldbuf_wdat", wdat_wb, 32'h13579BDF);
      chk("ldbuf_dst", regDst_wb, 5'd6);

      // Reset in the middle of a load wait
      set_instr(SEL_ALU, 32'h55, 32'h48, 32'h0, 0, 0, 1, 5'd2);
      run_instr(0, 1'b0, 1'b0, 32'h0);
      set_instr(SEL_MEM, 32'h600, 32'h4C, 32'h0, 1, 0, 1, 5'd10);
      step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      nRST = 1'b0;
      #1;
      chk("rst_wait_regWr", regWr_wb, 0);
      chk("rst_wait_regDst", regDst_wb, 0);
      chk("rst_wait_wdat", wdat_wb, 0);
      model_reset();
      #2;
      nRST = 1'b1;
      step(1'b1, 1'b0, 1'b0);
      chk("rst_reissue_stalls", stall_seen >= 1, 1);
      dmemload = 32'h2468ACE0;
      step(1'b1, 1'b1, 1'b0);
      chk("rst_reissue_wdat", wdat_wb, 32'h2468ACE0);
      chk("rst_reissue_dst", regDst_wb, 5'd10);

      // Randomized instructions against the reference
      for (int n = 0; n < 200; n++) begin
         int k;
         k = $urandom_range(0, 3);
         set_instr(2'($urandom_range(0, 3)), $urandom, $urandom, $urandom,
                   (k == 1) || (k == 3), (k == 2) || (k == 3),
                   1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
         run_instr($urandom_range(0, 4), ($urandom_range(0, 7) == 0), 1'b1, $urandom);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
